// File: rtl/ssd_pkg.sv
// Shared seven-segment constants: active-low abcdefg patterns and symbol code map.
package ssd_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned SEG_W  = 7;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [SEG_W-1:0]  seg_t;

    // Patterns are abcdefg with a in the MSB; a 0 lights the segment.
    localparam seg_t SEG_0   = 7'b0000001;
    localparam seg_t SEG_1   = 7'b1001111;
    localparam seg_t SEG_2   = 7'b0010010;
    localparam seg_t SEG_3   = 7'b0000110;
    localparam seg_t SEG_4   = 7'b1001100;
    localparam seg_t SEG_5   = 7'b0100100;
    localparam seg_t SEG_6   = 7'b0100000;
    localparam seg_t SEG_7   = 7'b0001111;
    localparam seg_t SEG_8   = 7'b0000000;
    localparam seg_t SEG_9   = 7'b0000100;
    localparam seg_t SEG_A   = 7'b0001000;
    localparam seg_t SEG_B   = 7'b1100000;
    localparam seg_t SEG_C   = 7'b0110001;
    localparam seg_t SEG_D   = 7'b1000010;
    localparam seg_t SEG_E   = 7'b0110000;
    localparam seg_t SEG_F   = 7'b0111000;
    localparam seg_t SEG_O   = 7'b1100010;
    localparam seg_t SEG_L   = 7'b1110001;
    localparam seg_t SEG_P   = 7'b0011000;
    localparam seg_t SEG_H   = 7'b1101000;
    localparam seg_t SEG_R   = 7'b1111010;
    localparam seg_t SEG_OFF = 7'b1111111;

    localparam code_t CODE_O     = 5'd16;
    localparam code_t CODE_L     = 5'd17;
    localparam code_t CODE_P     = 5'd18;
    localparam code_t CODE_H     = 5'd19;
    localparam code_t CODE_R     = 5'd20;
    localparam code_t CODE_BLANK = 5'd31;

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Code-set load port: valid/ready handshake carrying per-digit codes, dp and blink.
interface ssd_scan_driver_if #(
    parameter int unsigned DIGITS = 4
) ();
    import ssd_pkg::*;

    logic                     load_valid;
    logic                     load_ready;
    logic [CODE_W*DIGITS-1:0] digit_codes;
    logic [DIGITS-1:0]        dp_in;
    logic [DIGITS-1:0]        blink_en;

    modport master (
        output load_valid, digit_codes, dp_in, blink_en,
        input  load_ready
    );

    modport slave (
        input  load_valid, digit_codes, dp_in, blink_en,
        output load_ready
    );

endinterface

// File: rtl/int5bitToHexSSD_bankVer.sv
// Bank-version symbol decoder: 5-bit code to active-low abcdefg pattern.
module int5bitToHexSSD_bankVer
    import ssd_pkg::*;
(
    input  code_t code,
    output seg_t  seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (code)
            5'd0:   seg_c = SEG_0;
            5'd1:   seg_c = SEG_1;
            5'd2:   seg_c = SEG_2;
            5'd3:   seg_c = SEG_3;
            5'd4:   seg_c = SEG_4;
            5'd5:   seg_c = SEG_5;
            5'd6:   seg_c = SEG_6;
            5'd7:   seg_c = SEG_7;
            5'd8:   seg_c = SEG_8;
            5'd9:   seg_c = SEG_9;
            5'd10:  seg_c = SEG_A;
            5'd11:  seg_c = SEG_B;
            5'd12:  seg_c = SEG_C;
            5'd13:  seg_c = SEG_D;
            5'd14:  seg_c = SEG_E;
            5'd15:  seg_c = SEG_F;
            CODE_O: seg_c = SEG_O;
            CODE_L: seg_c = SEG_L;
            CODE_P: seg_c = SEG_P;
            CODE_H: seg_c = SEG_H;
            CODE_R: seg_c = SEG_R;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment driver with frame-synchronous code update,
// inter-digit blanking, per-digit blink and decimal point.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    ssd_scan_driver_if.slave  load,
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              frame_start
);

    localparam int unsigned SLOT_W = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
    localparam int unsigned DIG_W  = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned SET_W  = CODE_W * DIGITS;

    localparam logic [0:0] PH_BLANK = 1'b0;
    localparam logic [0:0] PH_SHOW  = 1'b1;

    logic [SLOT_W-1:0] slot_cnt, slot_n;
    logic [DIG_W-1:0]  digit_idx, digit_n;
    logic [FRM_W-1:0]  frame_cnt, frame_n;
    logic              blink_phase, phase_n;

    logic [SET_W-1:0]  act_codes, stg_codes;
    logic [DIGITS-1:0] act_dp, act_blink, stg_dp, stg_blink;
    logic              pending, pending_n;

    logic              take_c, apply_c, boundary_c;
    code_t             sel_code_c;
    logic              sel_dp_c, sel_blink_c;
    logic [DIGITS-1:0] an_sel_c, an_c;
    logic [0:0]        phase_c;
    logic              lit_c, dp_c, frame_start_c;
    seg_t              dec_seg_c, seg_c;

    // Scan counters: slot within digit, digit within frame, frame within blink half-period.
    always_comb begin
        slot_n  = slot_cnt;
        digit_n = digit_idx;
        frame_n = frame_cnt;
        phase_n = blink_phase;
        if (!enable) begin
            slot_n  = '0;
            digit_n = '0;
            frame_n = '0;
            phase_n = 1'b0;
        end else if (slot_cnt == SLOT_W'(REFRESH_DIV - 1)) begin
            slot_n = '0;
            if (digit_idx == DIG_W'(DIGITS - 1)) begin
                digit_n = '0;
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_n = '0;
                    phase_n = ~blink_phase;
                end else begin
                    frame_n = frame_cnt + FRM_W'(1);
                end
            end else begin
                digit_n = digit_idx + DIG_W'(1);
            end
        end else begin
            slot_n = slot_cnt + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            slot_cnt    <= slot_n;
            digit_idx   <= digit_n;
            frame_cnt   <= frame_n;
            blink_phase <= phase_n;
        end
    end

    // Staged set is promoted only at a frame boundary, or at once while the display is off.
    always_comb begin
        boundary_c = (slot_cnt == '0) && (digit_idx == '0);
        take_c     = load.load_valid && load.load_ready;
        apply_c    = pending && (boundary_c || !enable);
        pending_n  = pending;
        if (take_c) begin
            pending_n = 1'b1;
        end else if (apply_c) begin
            pending_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_codes       <= {DIGITS{CODE_BLANK}};
            act_dp          <= '0;
            act_blink       <= '0;
            stg_codes       <= {DIGITS{CODE_BLANK}};
            stg_dp          <= '0;
            stg_blink       <= '0;
            pending         <= 1'b0;
            load.load_ready <= 1'b0;
        end else begin
            if (take_c) begin
                stg_codes <= load.digit_codes;
                stg_dp    <= load.dp_in;
                stg_blink <= load.blink_en;
            end else if (apply_c) begin
                act_codes <= stg_codes;
                act_dp    <= stg_dp;
                act_blink <= stg_blink;
            end
            pending         <= pending_n;
            load.load_ready <= !pending_n;
        end
    end

    // Select the scanned digit's attributes so a single decoder serves all digits.
    always_comb begin
        sel_code_c  = CODE_BLANK;
        sel_dp_c    = 1'b0;
        sel_blink_c = 1'b0;
        an_sel_c    = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_idx == DIG_W'(i)) begin
                sel_code_c  = act_codes[i*CODE_W +: CODE_W];
                sel_dp_c    = act_dp[i];
                sel_blink_c = act_blink[i];
                an_sel_c[i] = 1'b1;
            end
        end
    end

    int5bitToHexSSD_bankVer u_dec (
        .code  (sel_code_c),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        phase_c       = (slot_cnt < SLOT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
        lit_c         = enable && (phase_c == PH_SHOW) && !(sel_blink_c && blink_phase);
        an_c          = lit_c ? ~an_sel_c : '1;
        seg_c         = lit_c ? dec_seg_c : SEG_OFF;
        dp_c          = lit_c ? ~sel_dp_c : 1'b1;
        frame_start_c = enable && boundary_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_c;
            seg         <= seg_c;
            dp          <= dp_c;
            frame_start <= frame_start_c;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: a cycle model predicts every pin each clock.
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int BF = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    always #5 clk = ~clk;

    ssd_scan_driver_if #(.DIGITS(ND)) lif ();

    ssd_scan_driver #(
        .DIGITS       (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (lif),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    int   m_slot, m_dig, m_frm;
    logic m_ph, m_pend, m_rdy, took;
    int   m_act[ND], m_stg[ND];
    logic m_adp[ND], m_abl[ND], m_sdp[ND], m_sbl[ND];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] ref_seg(input int c);
        case (c)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            16: return 7'b1100010;
            17: return 7'b1110001;
            18: return 7'b0011000;
            19: return 7'b1101000;
            20: return 7'b1111010;
            default: return 7'b1111111;
        endcase
    endfunction

    // Predict pins after the coming edge from the inputs now applied.
    task automatic model_step(output exp_t e);
        logic show;
        if (rst) begin
            e = '{seg: 7'h7f, dp: 1'b1, an: 4'hf, fs: 1'b0, rdy: 1'b0};
            m_slot = 0; m_dig = 0; m_frm = 0; m_ph = 1'b0;
            m_pend = 1'b0; m_rdy = 1'b0; took = 1'b0;
            for (int d = 0; d < ND; d++) begin
                m_act[d] = 31; m_stg[d] = 31;
                m_adp[d] = 1'b0; m_abl[d] = 1'b0; m_sdp[d] = 1'b0; m_sbl[d] = 1'b0;
            end
        end else begin
            show   = enable && (m_slot >= BC) && !(m_abl[m_dig] && m_ph);
            e.an   = show ? (4'hf ^ (4'b0001 << m_dig)) : 4'hf;
            e.seg  = show ? ref_seg(m_act[m_dig]) : 7'h7f;
            e.dp   = show ? ~m_adp[m_dig] : 1'b1;
            e.fs   = enable && (m_slot == 0) && (m_dig == 0);
            took   = lif.load_valid && m_rdy;
            if (took) begin
                for (int d = 0; d < ND; d++) begin
                    m_stg[d] = int'(lif.digit_codes[5*d +: 5]);
                    m_sdp[d] = lif.dp_in[d];
                    m_sbl[d] = lif.blink_en[d];
                end
                m_pend = 1'b1;
            end else if (m_pend && (!enable || (m_slot == 0 && m_dig == 0))) begin
                for (int d = 0; d < ND; d++) begin
                    m_act[d] = m_stg[d]; m_adp[d] = m_sdp[d]; m_abl[d] = m_sbl[d];
                end
                m_pend = 1'b0;
            end
            m_rdy = !m_pend;
            e.rdy = m_rdy;
            if (!enable) begin
                m_slot = 0; m_dig = 0; m_frm = 0; m_ph = 1'b0;
            end else begin
                m_slot++;
                if (m_slot == RD) begin
                    m_slot = 0;
                    m_dig++;
                    if (m_dig == ND) begin
                        m_dig = 0;
                        m_frm++;
                        if (m_frm == BF) begin
                            m_frm = 0;
                            m_ph  = ~m_ph;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("an",          32'(an),             32'(e.an));
        check("seg",         32'(seg),            32'(e.seg));
        check("dp",          32'(dp),             32'(e.dp));
        check("frame_start", 32'(frame_start),    32'(e.fs));
        check("load_ready",  32'(lif.load_ready), 32'(e.rdy));
    endtask

    task automatic load_set(input logic [19:0] codes, input logic [3:0] dpv, input logic [3:0] bl);
        lif.digit_codes = codes;
        lif.dp_in       = dpv;
        lif.blink_en    = bl;
        lif.load_valid  = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 80 && !took; i++) tick();
        lif.load_valid = 1'b0;
        check("load_taken", 32'(took), 32'd1);
    endtask

    task automatic wait_fs();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = frame_start;
        end
        check("fs_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int fs_cnt;
        rst             = 1'b1;
        enable          = 1'b1;
        lif.load_valid  = 1'b0;
        lif.digit_codes = '0;
        lif.dp_in       = '0;
        lif.blink_en    = '0;
        repeat (3) tick();
        check("rst_an",  32'(an),             32'hf);
        check("rst_seg", 32'(seg),            32'h7f);
        check("rst_rdy", 32'(lif.load_ready), 32'd0);

        // Idle scan after reset.
        rst = 1'b0;
        fs_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (frame_start) fs_cnt++;
            if (c == 0) check("rdy_after_rst", 32'(lif.load_ready), 32'd1);
            if (c == 2) check("idle_d0_an", 32'(an), 32'he);
            if (c == 4) check("idle_gap_an", 32'(an), 32'hf);
        end
        check("fs_count", 32'(fs_cnt), 32'd3);

        // Mid-frame load applied at the next boundary.
        load_set({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
        check("rdy_drop", 32'(lif.load_ready), 32'd0);
        wait_fs();
        tick();
        check("d0_seg_0", 32'(seg), 32'h01);
        check("d0_an",    32'(an),  32'he);
        repeat (12) tick();
        check("d3_seg_3", 32'(seg), 32'h06);
        check("d3_an",    32'(an),  32'h7);

        // Second set held while the first is still pending.
        load_set({5'd7, 5'd6, 5'd5, 5'd4}, 4'b0000, 4'b0000);
        load_set({5'd11, 5'd10, 5'd9, 5'd8}, 4'b1010, 4'b0000);
        repeat (40) tick();

        // Disable mid-slot, load while off, then blink on digit 0.
        repeat (5) tick();
        enable = 1'b0;
        load_set({5'd16, 5'd17, 5'd18, 5'd19}, 4'b0000, 4'b0001);
        check("off_an_0", 32'(an), 32'hf);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("off_an", 32'(an), 32'hf);
        end
        enable = 1'b1;
        for (int c = 0; c < 96; c++) begin
            tick();
            if (c == 0)  check("reen_fs",  32'(frame_start), 32'd1);
            if (c == 0)  check("reen_an",  32'(an),          32'hf);
            if (c == 1)  check("blink_f0_an",  32'(an),  32'he);
            if (c == 1)  check("blink_f0_seg", 32'(seg), 32'h68);
            if (c == 33) check("blink_f2_an",  32'(an),  32'hf);
            if (c == 37) check("d1_p_an",  32'(an),  32'hd);
            if (c == 37) check("d1_p_seg", 32'(seg), 32'h18);
            if (c == 65) check("blink_f4_an",  32'(an),  32'he);
        end

        // Blank code with decimal point on digit 2.
        load_set({5'd0, 5'd25, 5'd0, 5'd0}, 4'b0100, 4'b0000);
        wait_fs();
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) check("d0_dp_off", 32'(dp), 32'd1);
            if (c == 9) begin
                check("d2_seg_blank", 32'(seg), 32'h7f);
                check("d2_dp_on",     32'(dp),  32'd0);
                check("d2_an",        32'(an),  32'hb);
            end
        end

        // Reset mid-frame discards a pending set.
        load_set({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 4'b0000);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_an",  32'(an),             32'hf);
        check("rst_mid_rdy", 32'(lif.load_ready), 32'd0);
        rst = 1'b0;
        wait_fs();
        tick();
        check("post_rst_seg", 32'(seg), 32'h7f);
        check("post_rst_an",  32'(an),  32'he);
        repeat (16) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
